// File: rtl/gptp_tx_pkg.sv
// Shared types and default widths for the multi-channel gPTP transmit timestamp engine.
package gptp_tx_pkg;

    localparam int unsigned MSG_W_DEF = 352;
    localparam int unsigned TS_W_DEF  = 80;

    typedef enum logic [2:0] {
        ST_FREE = 3'd0,
        ST_PEND = 3'd1,
        ST_INFL = 3'd2,
        ST_DONE = 3'd3,
        ST_TOUT = 3'd4
    } slot_stat_e;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_SEND = 2'd1,
        CH_WAIT = 2'd2
    } chan_state_e;

endpackage

// File: rtl/gptp_tx_chan.sv
// One egress channel: claims a pending slot, sends its message, then waits for
// the returned timestamp or a timeout and reports the completion to the slot table.
module gptp_tx_chan
    import gptp_tx_pkg::*;
#(
    parameter int unsigned AW      = 3,
    parameter int unsigned MSG_W   = MSG_W_DEF,
    parameter int unsigned TS_W    = TS_W_DEF,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel_vaild,
    input  logic [AW-1:0]    sel_addr,
    input  logic [MSG_W-1:0] sel_data,
    output logic             grab,
    output logic             ts_vaild,
    input  logic             ts_ready,
    output logic [MSG_W-1:0] ts_data,
    input  logic             rv_vaild,
    input  logic [TS_W-1:0]  rv_data,
    output logic             comp_vaild,
    output logic             comp_tout,
    output logic [AW-1:0]    comp_addr,
    output logic [TS_W-1:0]  comp_ts,
    output logic             ts_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    chan_state_e       state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [AW-1:0]     slot_addr;

    assign comp_addr = slot_addr;

    always_comb begin
        state_next = state;
        grab       = 1'b0;
        ts_vaild   = 1'b0;
        comp_vaild = 1'b0;
        comp_tout  = 1'b0;
        comp_ts    = rv_data;
        case (state)
            CH_IDLE: begin
                if (sel_vaild) begin
                    grab       = 1'b1;
                    state_next = CH_SEND;
                end
            end
            CH_SEND: begin
                ts_vaild = 1'b1;
                if (ts_ready) state_next = CH_WAIT;
            end
            CH_WAIT: begin
                // a timestamp arriving on the expiry cycle still completes as DONE
                if (rv_vaild) begin
                    comp_vaild = 1'b1;
                    state_next = CH_IDLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    comp_vaild = 1'b1;
                    comp_tout  = 1'b1;
                    comp_ts    = '1;
                    state_next = CH_IDLE;
                end
            end
            default: state_next = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CH_IDLE;
            cnt       <= '0;
            slot_addr <= '0;
            ts_data   <= '0;
            ts_err    <= 1'b0;
        end else begin
            state <= state_next;
            if (grab) begin
                slot_addr <= sel_addr;
                ts_data   <= sel_data;
            end
            if (state == CH_SEND && ts_ready) begin
                cnt <= '0;
            end else if (state == CH_WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (rv_vaild && state != CH_WAIT) ts_err <= 1'b1;
        end
    end

endmodule

// File: rtl/gptp_tx_ts_engine.sv
// Shared message slot table served by CH egress channels; each channel picks its
// lowest-index pending slot and writes the returned timestamp back into the table.
module gptp_tx_ts_engine
    import gptp_tx_pkg::*;
#(
    parameter int unsigned CH      = 2,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned AW      = $clog2(DEPTH),
    parameter int unsigned CW      = (CH > 1) ? $clog2(CH) : 1,
    parameter int unsigned MSG_W   = MSG_W_DEF,
    parameter int unsigned TS_W    = TS_W_DEF,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                gptp_wr_vaild,
    output logic                gptp_wr_ready,
    input  logic [AW-1:0]       gptp_wr_addr,
    input  logic [CW-1:0]       gptp_wr_ch,
    input  logic [MSG_W-1:0]    gptp_wr_data,
    input  logic                gptp_rel_vaild,
    input  logic [AW-1:0]       gptp_rel_addr,
    input  logic [AW-1:0]       gptp_rd_addr,
    output logic [TS_W-1:0]     gptp_rd_data,
    output logic [2:0]          gptp_rd_stat,
    output logic                gptp_done_pulse,
    output logic [CH-1:0]       gptp_ts_vaild,
    input  logic [CH-1:0]       gptp_ts_ready,
    output logic [CH*MSG_W-1:0] gptp_ts_data,
    input  logic [CH-1:0]       gptp_ts_rv_vaild,
    input  logic [CH*TS_W-1:0]  gptp_ts_rv_data,
    output logic [CH-1:0]       gptp_ts_err
);

    slot_stat_e       stat_mem [DEPTH];
    logic [TS_W-1:0]  ts_mem   [DEPTH];
    logic [CW-1:0]    tag_mem  [DEPTH];
    logic [MSG_W-1:0] msg_mem  [DEPTH];

    logic [CH-1:0]    sel_hit;
    logic [AW-1:0]    sel_idx   [CH];
    logic [CH-1:0]    grab;
    logic [CH-1:0]    comp_vaild;
    logic [CH-1:0]    comp_tout;
    logic [AW-1:0]    comp_addr [CH];
    logic [TS_W-1:0]  comp_ts   [CH];
    logic             wr_fire;

    assign gptp_wr_ready = (stat_mem[gptp_wr_addr] == ST_FREE);
    assign wr_fire       = gptp_wr_vaild && gptp_wr_ready;

    always_comb begin
        for (int unsigned c = 0; c < CH; c++) begin
            sel_hit[c] = 1'b0;
            sel_idx[c] = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (!sel_hit[c] && stat_mem[i] == ST_PEND && tag_mem[i] == CW'(c)) begin
                    sel_hit[c] = 1'b1;
                    sel_idx[c] = AW'(i);
                end
            end
        end
    end

    // write, claim, completion and release each act only on a distinct slot state,
    // so at most one of them can hit a given slot in any cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stat_mem[i] <= ST_FREE;
                ts_mem[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_fire && gptp_wr_addr == AW'(i)) stat_mem[i] <= ST_PEND;
                if (gptp_rel_vaild && gptp_rel_addr == AW'(i) &&
                    (stat_mem[i] == ST_DONE || stat_mem[i] == ST_TOUT)) begin
                    stat_mem[i] <= ST_FREE;
                end
                for (int unsigned c = 0; c < CH; c++) begin
                    if (grab[c] && sel_idx[c] == AW'(i)) stat_mem[i] <= ST_INFL;
                    if (comp_vaild[c] && comp_addr[c] == AW'(i)) begin
                        stat_mem[i] <= comp_tout[c] ? ST_TOUT : ST_DONE;
                        ts_mem[i]   <= comp_ts[c];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            msg_mem[gptp_wr_addr] <= gptp_wr_data;
            tag_mem[gptp_wr_addr] <= gptp_wr_ch;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gptp_rd_data    <= '0;
            gptp_rd_stat    <= '0;
            gptp_done_pulse <= 1'b0;
        end else begin
            gptp_rd_data    <= ts_mem[gptp_rd_addr];
            gptp_rd_stat    <= stat_mem[gptp_rd_addr];
            gptp_done_pulse <= |comp_vaild;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_chan
        gptp_tx_chan #(
            .AW      (AW),
            .MSG_W   (MSG_W),
            .TS_W    (TS_W),
            .TIMEOUT (TIMEOUT)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .sel_vaild  (sel_hit[c]),
            .sel_addr   (sel_idx[c]),
            .sel_data   (msg_mem[sel_idx[c]]),
            .grab       (grab[c]),
            .ts_vaild   (gptp_ts_vaild[c]),
            .ts_ready   (gptp_ts_ready[c]),
            .ts_data    (gptp_ts_data[c*MSG_W +: MSG_W]),
            .rv_vaild   (gptp_ts_rv_vaild[c]),
            .rv_data    (gptp_ts_rv_data[c*TS_W +: TS_W]),
            .comp_vaild (comp_vaild[c]),
            .comp_tout  (comp_tout[c]),
            .comp_addr  (comp_addr[c]),
            .comp_ts    (comp_ts[c]),
            .ts_err     (gptp_ts_err[c])
        );
    end

endmodule
